// File: rtl/core_lsu.sv
// Load/store unit between the EX/MEM register and a request/grant data bus.
// One access in flight at a time; loads are extracted and extended into mem_data_o.
module core_lsu #(
  parameter int XLEN = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid_i,
  input  logic              mem_read_i,
  input  logic              mem_write_i,
  input  logic [2:0]        funct3_i,
  input  logic [XLEN-1:0]   alu_i,
  input  logic [XLEN-1:0]   rs2_data_i,
  output logic [XLEN-1:0]   mem_data_o,
  output logic              stall_o,
  output logic              misalign_o,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [XLEN-1:0]   dmem_addr_o,
  output logic [XLEN-1:0]   dmem_wdata_o,
  output logic [XLEN/8-1:0] dmem_wstrb_o,
  input  logic              dmem_gnt_i,
  input  logic              dmem_rvalid_i,
  input  logic [XLEN-1:0]   dmem_rdata_i
);
  localparam int SW = XLEN / 8;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [XLEN-1:0]   mem_data_q, mem_data_d;
  logic [2:0]        funct3_q, funct3_d;
  logic              we_q, we_d;

  logic              access;
  logic              aligned;
  logic [5:0]        byte_shift;
  logic [XLEN-1:0]   rdata_shifted;
  logic [XLEN-1:0]   load_ext;
  logic [SW-1:0]     strb_base;

  // Gating with rst_n keeps stall/misalign quiet while reset is held.
  assign access = rst_n & ex_valid_i & (mem_read_i | mem_write_i);

  // funct3[1:0] encodes the size for every code, including 111 as a double.
  always_comb begin
    case (funct3_i[1:0])
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = ~alu_i[0];
      2'b10:   aligned = (alu_i[1:0] == 2'b00);
      default: aligned = (alu_i[2:0] == 3'b000);
    endcase
  end

  assign byte_shift    = {addr_q[2:0], 3'b000};
  assign rdata_shifted = dmem_rdata_i >> byte_shift;

  always_comb begin
    case (funct3_q[1:0])
      2'b00: load_ext = funct3_q[2] ? {{(XLEN-8){1'b0}}, rdata_shifted[7:0]}
                                    : {{(XLEN-8){rdata_shifted[7]}}, rdata_shifted[7:0]};
      2'b01: load_ext = funct3_q[2] ? {{(XLEN-16){1'b0}}, rdata_shifted[15:0]}
                                    : {{(XLEN-16){rdata_shifted[15]}}, rdata_shifted[15:0]};
      2'b10: load_ext = funct3_q[2] ? {{(XLEN-32){1'b0}}, rdata_shifted[31:0]}
                                    : {{(XLEN-32){rdata_shifted[31]}}, rdata_shifted[31:0]};
      default: load_ext = rdata_shifted;
    endcase
  end

  always_comb begin
    case (funct3_q[1:0])
      2'b00:   strb_base = SW'(8'h01);
      2'b01:   strb_base = SW'(8'h03);
      2'b10:   strb_base = SW'(8'h0F);
      default: strb_base = SW'(8'hFF);
    endcase
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    funct3_d   = funct3_q;
    we_d       = we_q;
    mem_data_d = mem_data_q;
    stall_o    = 1'b0;
    misalign_o = 1'b0;
    dmem_req_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (access) begin
          if (aligned) begin
            addr_d   = alu_i;
            wdata_d  = rs2_data_i;
            funct3_d = funct3_i;
            we_d     = mem_write_i;
            stall_o  = 1'b1;
            state_d  = REQ;
          end else begin
            misalign_o = 1'b1;
          end
        end
      end
      REQ: begin
        dmem_req_o = 1'b1;
        stall_o    = 1'b1;
        if (dmem_gnt_i) state_d = we_q ? DONE : WAIT;
      end
      WAIT: begin
        stall_o = 1'b1;
        if (dmem_rvalid_i) begin
          mem_data_d = load_ext;
          state_d    = DONE;
        end
      end
      // EX/MEM still shows the retiring instruction here, so nothing is accepted.
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      funct3_q   <= '0;
      we_q       <= 1'b0;
      mem_data_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      funct3_q   <= funct3_d;
      we_q       <= we_d;
      mem_data_q <= mem_data_d;
    end
  end

  assign mem_data_o   = mem_data_q;
  assign dmem_addr_o  = {addr_q[XLEN-1:3], 3'b000};
  assign dmem_we_o    = (state_q == REQ) & we_q;
  assign dmem_wdata_o = wdata_q << byte_shift;
  assign dmem_wstrb_o = dmem_we_o ? (strb_base << addr_q[2:0]) : '0;

endmodule

// File: tb/tb_core_lsu.sv
// Directed bench for core_lsu: each task drives one scenario and checks against
// hand-computed values; one line is printed per transaction.
module tb_core_lsu;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid_i, mem_read_i, mem_write_i;
  logic [2:0]  funct3_i;
  logic [63:0] alu_i, rs2_data_i;
  logic [63:0] mem_data_o;
  logic        stall_o, misalign_o, dmem_req_o, dmem_we_o;
  logic [63:0] dmem_addr_o, dmem_wdata_o;
  logic [7:0]  dmem_wstrb_o;
  logic        dmem_gnt_i, dmem_rvalid_i;
  logic [63:0] dmem_rdata_i;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  core_lsu #(.XLEN(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid_i(ex_valid_i), .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
    .funct3_i(funct3_i), .alu_i(alu_i), .rs2_data_i(rs2_data_i),
    .mem_data_o(mem_data_o), .stall_o(stall_o), .misalign_o(misalign_o),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_wdata_o(dmem_wdata_o), .dmem_wstrb_o(dmem_wstrb_o),
    .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i)
  );

  task automatic idle_inputs();
    ex_valid_i = 1'b0; mem_read_i = 1'b0; mem_write_i = 1'b0;
    funct3_i = 3'b000; alu_i = 64'h0; rs2_data_i = 64'h0;
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = 64'hDEADBEEF_CAFEF00D;
  endtask

  // Bus responder: called at posedge+1 in IDLE, returns at posedge+2 of the DONE cycle
  // with the access still presented.
  task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                            input logic [63:0] addr, input logic [63:0] rs2,
                            input int gnt_wait, input logic [63:0] rdata,
                            output int stall_cnt, output int req_cnt,
                            output logic [63:0] addr_seen, output logic [63:0] wdata_seen,
                            output logic [7:0] wstrb_seen, output logic we_seen,
                            output logic stable_ok, output logic timed_out);
    logic rv_pend;
    rv_pend = 1'b0; stall_cnt = 0; req_cnt = 0; stable_ok = 1'b1; timed_out = 1'b1;
    addr_seen = '0; wdata_seen = '0; wstrb_seen = '0; we_seen = 1'b0;
    ex_valid_i = 1'b1; mem_read_i = rd; mem_write_i = wr; funct3_i = f3;
    alu_i = addr; rs2_data_i = rs2;
    for (int cyc = 0; cyc < 24; cyc++) begin
      dmem_rvalid_i = rv_pend;
      dmem_rdata_i  = rv_pend ? rdata : 64'hDEADBEEF_CAFEF00D;
      rv_pend = 1'b0;
      dmem_gnt_i = 1'b0;
      #1;
      if (cyc > 0 && stall_o === 1'b0) begin
        timed_out = 1'b0;
        break;
      end
      if (stall_o === 1'b1) stall_cnt++;
      if (dmem_req_o === 1'b1) begin
        if (req_cnt == 0) begin
          addr_seen = dmem_addr_o; wdata_seen = dmem_wdata_o;
          wstrb_seen = dmem_wstrb_o; we_seen = dmem_we_o;
        end else if (dmem_addr_o !== addr_seen || dmem_wdata_o !== wdata_seen ||
                     dmem_wstrb_o !== wstrb_seen || dmem_we_o !== we_seen ||
                     stall_o !== 1'b1) begin
          stable_ok = 1'b0;
        end
        req_cnt++;
        if (req_cnt > gnt_wait) begin
          dmem_gnt_i = 1'b1;
          rv_pend = rd & ~wr;
        end
      end
      @(posedge clk); #1;
    end
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    @(posedge clk); #1;
    ex_valid_i = 1'b1; mem_read_i = 1'b1; funct3_i = 3'b011; alu_i = 64'h8;
    dmem_gnt_i = 1'b1; dmem_rvalid_i = 1'b1;
    #1;
    $display("RESET stall=%b misalign=%b req=%b mem_data=%h", stall_o, misalign_o, dmem_req_o, mem_data_o);
    checks++; if (stall_o !== 1'b0) begin failures++; $display("FAIL reset_stall: got %b expected 0", stall_o); end
    checks++; if (misalign_o !== 1'b0) begin failures++; $display("FAIL reset_misalign: got %b expected 0", misalign_o); end
    checks++; if (dmem_req_o !== 1'b0 || dmem_we_o !== 1'b0) begin failures++; $display("FAIL reset_req_we: got %b%b expected 00", dmem_req_o, dmem_we_o); end
    checks++; if (dmem_wstrb_o !== 8'h00) begin failures++; $display("FAIL reset_wstrb: got %h expected 00", dmem_wstrb_o); end
    checks++; if (mem_data_o !== 64'h0) begin failures++; $display("FAIL reset_mem_data: got %h expected 0", mem_data_o); end
    checks++; if (dmem_addr_o !== 64'h0 || dmem_wdata_o !== 64'h0) begin failures++; $display("FAIL reset_fields: got %h/%h expected 0/0", dmem_addr_o, dmem_wdata_o); end
    idle_inputs();
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_lb(input logic [2:0] f3, input logic [63:0] exp, input string tag);
    int sc, rc; logic [63:0] a, w; logic [7:0] s; logic we, st, to;
    run_access(1'b1, 1'b0, f3, 64'h1003, 64'h0, 0, 64'h00000000_F0000000, sc, rc, a, w, s, we, st, to);
    $display("%s addr=1003 data=%h stall=%0d", tag, mem_data_o, sc);
    checks++; if (to !== 1'b0) begin failures++; $display("FAIL %s_timeout: no completion within bound", tag); end
    checks++; if (mem_data_o !== exp) begin failures++; $display("FAIL %s_data: got %h expected %h", tag, mem_data_o, exp); end
    checks++; if (sc !== 3) begin failures++; $display("FAIL %s_stall: got %0d expected 3", tag, sc); end
    checks++; if (a !== 64'h1000 || we !== 1'b0 || s !== 8'h00) begin failures++; $display("FAIL %s_bus: got %h/%b/%h expected 1000/0/00", tag, a, we, s); end
    idle_inputs(); @(posedge clk); #1;
  endtask

  task automatic test_store(input logic rd, input logic [2:0] f3, input logic [63:0] addr,
                            input logic [63:0] rs2, input logic [63:0] exp_addr,
                            input logic [63:0] exp_wdata, input logic [7:0] exp_strb,
                            input logic [63:0] exp_mem, input string tag);
    int sc, rc; logic [63:0] a, w; logic [7:0] s; logic we, st, to;
    run_access(rd, 1'b1, f3, addr, rs2, 0, 64'h0, sc, rc, a, w, s, we, st, to);
    $display("%s addr=%h wdata=%h wstrb=%h stall=%0d", tag, a, w, s, sc);
    checks++; if (to !== 1'b0) begin failures++; $display("FAIL %s_timeout: no completion within bound", tag); end
    checks++; if (a !== exp_addr) begin failures++; $display("FAIL %s_addr: got %h expected %h", tag, a, exp_addr); end
    checks++; if (w !== exp_wdata) begin failures++; $display("FAIL %s_wdata: got %h expected %h", tag, w, exp_wdata); end
    checks++; if (s !== exp_strb || we !== 1'b1) begin failures++; $display("FAIL %s_strb_we: got %h/%b expected %h/1", tag, s, we, exp_strb); end
    checks++; if (sc !== 2) begin failures++; $display("FAIL %s_stall: got %0d expected 2", tag, sc); end
    checks++; if (mem_data_o !== exp_mem) begin failures++; $display("FAIL %s_mem_hold: got %h expected %h", tag, mem_data_o, exp_mem); end
    idle_inputs(); @(posedge clk); #1;
  endtask

  task automatic test_ld_gnt_delay();
    int sc, rc; logic [63:0] a, w; logic [7:0] s; logic we, st, to;
    run_access(1'b1, 1'b0, 3'b011, 64'h3008, 64'h0, 3, 64'h01234567_89ABCDEF, sc, rc, a, w, s, we, st, to);
    $display("LD addr=%h data=%h req_cycles=%0d stall=%0d", a, mem_data_o, rc, sc);
    checks++; if (to !== 1'b0) begin failures++; $display("FAIL ld_timeout: no completion within bound"); end
    checks++; if (rc !== 4) begin failures++; $display("FAIL ld_req_cycles: got %0d expected 4", rc); end
    checks++; if (st !== 1'b1 || a !== 64'h3008) begin failures++; $display("FAIL ld_stable: got stable=%b addr=%h expected 1/3008", st, a); end
    checks++; if (sc !== 6) begin failures++; $display("FAIL ld_stall: got %0d expected 6", sc); end
    checks++; if (mem_data_o !== 64'h01234567_89ABCDEF) begin failures++; $display("FAIL ld_data: got %h expected 0123456789abcdef", mem_data_o); end
    idle_inputs(); @(posedge clk); #1;
  endtask

  task automatic test_misalign();
    logic saw_req, saw_stall;
    saw_req = 1'b0; saw_stall = 1'b0;
    ex_valid_i = 1'b1; mem_read_i = 1'b1; funct3_i = 3'b010; alu_i = 64'h1002;
    #1;
    $display("LW_MISALIGN addr=1002 misalign=%b stall=%b req=%b", misalign_o, stall_o, dmem_req_o);
    checks++; if (misalign_o !== 1'b1) begin failures++; $display("FAIL misalign_flag: got %b expected 1", misalign_o); end
    for (int i = 0; i < 3; i++) begin
      if (dmem_req_o !== 1'b0) saw_req = 1'b1;
      if (stall_o !== 1'b0) saw_stall = 1'b1;
      @(posedge clk); #2;
    end
    checks++; if (saw_req !== 1'b0) begin failures++; $display("FAIL misalign_req: got 1 expected 0"); end
    checks++; if (saw_stall !== 1'b0) begin failures++; $display("FAIL misalign_stall: got 1 expected 0"); end
    checks++; if (mem_data_o !== 64'h01234567_89ABCDEF) begin failures++; $display("FAIL misalign_mem_hold: got %h expected 0123456789abcdef", mem_data_o); end
    funct3_i = 3'b111; alu_i = 64'h1004;
    #1;
    $display("F3_111_MISALIGN addr=1004 misalign=%b", misalign_o);
    checks++; if (misalign_o !== 1'b1 || stall_o !== 1'b0) begin failures++; $display("FAIL misalign_f3_111: got %b/%b expected 1/0", misalign_o, stall_o); end
    idle_inputs(); @(posedge clk); #1;
  endtask

  task automatic test_reset_in_wait();
    ex_valid_i = 1'b1; mem_read_i = 1'b1; funct3_i = 3'b010; alu_i = 64'h4000;
    @(posedge clk); #1;
    checks++; if (dmem_req_o !== 1'b1) begin failures++; $display("FAIL rstwait_req: got %b expected 1", dmem_req_o); end
    dmem_gnt_i = 1'b1;
    @(posedge clk); #1;
    idle_inputs();
    #1;
    checks++; if (stall_o !== 1'b1) begin failures++; $display("FAIL rstwait_wait_stall: got %b expected 1", stall_o); end
    rst_n = 1'b0;
    #1;
    $display("RESET_IN_WAIT req=%b stall=%b mem_data=%h", dmem_req_o, stall_o, mem_data_o);
    checks++; if (dmem_req_o !== 1'b0 || stall_o !== 1'b0) begin failures++; $display("FAIL rstwait_outputs: got %b/%b expected 0/0", dmem_req_o, stall_o); end
    checks++; if (mem_data_o !== 64'h0) begin failures++; $display("FAIL rstwait_mem_data: got %h expected 0", mem_data_o); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    dmem_rvalid_i = 1'b1; dmem_rdata_i = 64'hFFFFFFFF_FFFFFFFF;
    @(posedge clk); #1;
    dmem_rvalid_i = 1'b0;
    #1;
    $display("LATE_RVALID mem_data=%h stall=%b", mem_data_o, stall_o);
    checks++; if (mem_data_o !== 64'h0 || stall_o !== 1'b0) begin failures++; $display("FAIL rstwait_late_rvalid: got %h/%b expected 0/0", mem_data_o, stall_o); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int sc, rc; logic [63:0] a, w; logic [7:0] s; logic we, st, to;
    run_access(1'b1, 1'b0, 3'b001, 64'h5002, 64'h0, 0, 64'h00000000_80010000, sc, rc, a, w, s, we, st, to);
    $display("B2B_LH addr=%h data=%h stall=%0d", a, mem_data_o, sc);
    checks++; if (to !== 1'b0 || mem_data_o !== 64'hFFFFFFFF_FFFF8001) begin failures++; $display("FAIL b2b_first_data: got %h expected ffffffffffff8001", mem_data_o); end
    checks++; if (dmem_req_o !== 1'b0 || stall_o !== 1'b0) begin failures++; $display("FAIL b2b_done_accept: got req=%b stall=%b expected 0/0", dmem_req_o, stall_o); end
    @(posedge clk); #1;
    run_access(1'b1, 1'b0, 3'b110, 64'h5104, 64'h0, 0, 64'h89ABCDEF_00000000, sc, rc, a, w, s, we, st, to);
    $display("B2B_LWU addr=%h data=%h stall=%0d", a, mem_data_o, sc);
    checks++; if (to !== 1'b0 || a !== 64'h5100) begin failures++; $display("FAIL b2b_second_addr: got %h expected 5100", a); end
    checks++; if (sc !== 3) begin failures++; $display("FAIL b2b_second_stall: got %0d expected 3", sc); end
    checks++; if (mem_data_o !== 64'h00000000_89ABCDEF) begin failures++; $display("FAIL b2b_second_data: got %h expected 0000000089abcdef", mem_data_o); end
    idle_inputs(); @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_lb(3'b000, 64'hFFFFFFFF_FFFFFFF0, "LB");
    test_lb(3'b100, 64'h00000000_000000F0, "LBU");
    test_store(1'b0, 3'b001, 64'h2006, 64'h11112222_3333ABCD, 64'h2000,
               64'hABCD0000_00000000, 8'hC0, 64'h00000000_000000F0, "SH");
    test_store(1'b1, 3'b000, 64'h6001, 64'h77777777_7777775A, 64'h6000,
               64'h77777777_77775A00, 8'h02, 64'h00000000_000000F0, "SB_RW");
    test_ld_gnt_delay();
    test_misalign();
    test_reset_in_wait();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
